// File: rtl/l1_loader_pkg.sv
// Shared constants and FSM state type for the L1 signalling bus writer.
// Holds the default L1 block length and the loader state encoding.
package l1_loader_pkg;

    // Number of bytes in one L1 block unless overridden per instance.
    localparam int L1_LEN_BYTES_DEF = 32;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } l1_state_t;

endpackage

// File: rtl/l1_shadow_buf.sv
// Byte-addressed shadow register array for one L1 block.
// Ports: clk, rst_n (async, active-low), we/addr/data byte write, bus = flat view.
module l1_shadow_buf
    import l1_loader_pkg::*;
#(
    parameter int N_BYTES = L1_LEN_BYTES_DEF,
    parameter int ADDR_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [BYTE_W-1:0]         data,
    output logic [BYTE_W*N_BYTES-1:0] bus
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus <= '0;
        end else if (we) begin
            bus[{addr, 3'b000} +: BYTE_W] <= data;
        end
    end

endmodule

// File: rtl/l1_loader.sv
// Assembles an L1 byte stream into a shadow block and commits it to the
// active L1 bus on a frame-boundary UPDATE strobe.
// Ports: CLK, RST (async, active-low); DATA_IN/ENA/SOP byte stream;
//   UPDATE commit strobe; L1_BUS_OUT active block (byte i at [8i+7:8i]);
//   L1_VALID, L1_CHANGED, PENDING status; ERR_SHORT/ERR_LONG error pulses.
module l1_loader
    import l1_loader_pkg::*;
#(
    parameter int L1_LEN_BYTES = L1_LEN_BYTES_DEF,
    parameter int CNT_W        = 7
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [BYTE_W-1:0]              DATA_IN,
    input  logic                           ENA,
    input  logic                           SOP,
    input  logic                           UPDATE,
    output logic [BYTE_W*L1_LEN_BYTES-1:0] L1_BUS_OUT,
    output logic                           L1_VALID,
    output logic                           L1_CHANGED,
    output logic                           PENDING,
    output logic                           ERR_SHORT,
    output logic                           ERR_LONG
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(L1_LEN_BYTES - 1);

    l1_state_t                     state, state_n;
    logic [CNT_W-1:0]              cnt, cnt_n;
    logic                          pend_n;
    logic                          short_n, long_n;
    logic                          we;
    logic [CNT_W-1:0]              waddr;
    logic [BYTE_W*L1_LEN_BYTES-1:0] shadow;
    logic                          commit;

    l1_shadow_buf #(
        .N_BYTES (L1_LEN_BYTES),
        .ADDR_W  (CNT_W)
    ) u_shadow (
        .clk   (CLK),
        .rst_n (RST),
        .we    (we),
        .addr  (waddr),
        .data  (DATA_IN),
        .bus   (shadow)
    );

    // A commit samples the shadow as it stands before this edge, so a
    // SOP arriving in the same cycle cannot corrupt the committed block.
    assign commit = UPDATE && PENDING;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = PENDING;
        short_n = 1'b0;
        long_n  = 1'b0;
        we      = 1'b0;
        waddr   = '0;

        if (commit) begin
            pend_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (ENA && SOP) begin
                    we      = 1'b1;
                    waddr   = '0;
                    cnt_n   = CNT_W'(1);
                    pend_n  = 1'b0;
                    state_n = LOAD;
                end else if (ENA) begin
                    long_n = 1'b1;
                end
            end
            LOAD: begin
                if (ENA && SOP) begin
                    we      = 1'b1;
                    waddr   = '0;
                    cnt_n   = CNT_W'(1);
                    short_n = 1'b1;
                end else if (ENA) begin
                    we    = 1'b1;
                    waddr = cnt;
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        pend_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            PENDING    <= 1'b0;
            ERR_SHORT  <= 1'b0;
            ERR_LONG   <= 1'b0;
            L1_BUS_OUT <= '0;
            L1_VALID   <= 1'b0;
            L1_CHANGED <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            PENDING    <= pend_n;
            ERR_SHORT  <= short_n;
            ERR_LONG   <= long_n;
            L1_CHANGED <= 1'b0;
            if (commit) begin
                L1_BUS_OUT <= shadow;
                L1_VALID   <= 1'b1;
                // First commit always counts as a change.
                L1_CHANGED <= (shadow != L1_BUS_OUT) || !L1_VALID;
            end
        end
    end

endmodule

// File: tb/tb_l1_loader.sv
// Directed self-checking bench for l1_loader.
// Each scenario task drives stimulus and checks results inline.
module tb_l1_loader;

    localparam int N = 32;
    localparam int W = 8 * N;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [7:0]   DATA_IN = 8'h00;
    logic         ENA = 1'b0;
    logic         SOP = 1'b0;
    logic         UPDATE = 1'b0;
    logic [W-1:0] L1_BUS_OUT;
    logic         L1_VALID;
    logic         L1_CHANGED;
    logic         PENDING;
    logic         ERR_SHORT;
    logic         ERR_LONG;

    int errors = 0;
    int checks = 0;

    int n_changed = 0;
    int n_short   = 0;
    int n_long    = 0;

    logic [W-1:0] exp_bus;

    l1_loader #(.L1_LEN_BYTES(N), .CNT_W(7)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_IN    (DATA_IN),
        .ENA        (ENA),
        .SOP        (SOP),
        .UPDATE     (UPDATE),
        .L1_BUS_OUT (L1_BUS_OUT),
        .L1_VALID   (L1_VALID),
        .L1_CHANGED (L1_CHANGED),
        .PENDING    (PENDING),
        .ERR_SHORT  (ERR_SHORT),
        .ERR_LONG   (ERR_LONG)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (L1_CHANGED) n_changed++;
        if (ERR_SHORT)  n_short++;
        if (ERR_LONG)   n_long++;
    end

    task automatic send_byte(input logic [7:0] d, input logic s);
        DATA_IN = d;
        ENA     = 1'b1;
        SOP     = s;
        @(posedge CLK);
        #1;
        ENA = 1'b0;
        SOP = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] base, input logic ramp);
        for (int i = 0; i < N; i++) begin
            if (ramp) send_byte(base + 8'(i), i == 0);
            else      send_byte(base, i == 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_update;
        UPDATE = 1'b1;
        @(posedge CLK);
        #1;
        UPDATE = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        idle_cycles(2);
        checks++;
        if (L1_BUS_OUT !== '0) begin
            errors++;
            $display("FAIL reset_bus got=%h want=0", L1_BUS_OUT);
        end
        checks++;
        if ({L1_VALID, L1_CHANGED, PENDING, ERR_SHORT, ERR_LONG} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000",
                     {L1_VALID, L1_CHANGED, PENDING, ERR_SHORT, ERR_LONG});
        end
        @(negedge CLK);
        RST = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_clean_load;
        int c0;
        c0 = n_changed;
        for (int i = 0; i < N; i++) exp_bus[8*i +: 8] = 8'(i);
        send_block(8'h00, 1'b1);
        checks++;
        if (PENDING !== 1'b1) begin
            errors++;
            $display("FAIL clean_pending got=%b want=1", PENDING);
        end
        checks++;
        if (L1_BUS_OUT !== '0) begin
            errors++;
            $display("FAIL clean_precommit got=%h want=0", L1_BUS_OUT);
        end
        pulse_update();
        checks++;
        if (L1_BUS_OUT[7:0] !== 8'h00 || L1_BUS_OUT[8*16 +: 8] !== 8'h10) begin
            errors++;
            $display("FAIL clean_bytes got=%h/%h want=00/10",
                     L1_BUS_OUT[7:0], L1_BUS_OUT[8*16 +: 8]);
        end
        checks++;
        if (L1_BUS_OUT !== exp_bus) begin
            errors++;
            $display("FAIL clean_bus got=%h want=%h", L1_BUS_OUT, exp_bus);
        end
        checks++;
        if ({L1_VALID, L1_CHANGED, PENDING} !== 3'b110) begin
            errors++;
            $display("FAIL clean_flags got=%b want=110",
                     {L1_VALID, L1_CHANGED, PENDING});
        end
        idle_cycles(2);
        checks++;
        if (n_changed - c0 !== 1) begin
            errors++;
            $display("FAIL clean_changed_count got=%0d want=1", n_changed - c0);
        end
    endtask

    task automatic test_identical_reload;
        int c0;
        c0 = n_changed;
        send_block(8'h00, 1'b1);
        pulse_update();
        checks++;
        if (L1_BUS_OUT !== exp_bus || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL reload_bus got=%h pend=%b want=%h pend=0",
                     L1_BUS_OUT, PENDING, exp_bus);
        end
        idle_cycles(2);
        checks++;
        if (n_changed - c0 !== 0) begin
            errors++;
            $display("FAIL reload_changed got=%0d want=0", n_changed - c0);
        end
    endtask

    task automatic test_short_block;
        int s0;
        int c0;
        s0 = n_short;
        c0 = n_changed;
        for (int i = 0; i < 10; i++) send_byte(8'hAA, i == 0);
        send_byte(8'h55, 1'b1);
        checks++;
        if (ERR_SHORT !== 1'b1) begin
            errors++;
            $display("FAIL short_pulse got=%b want=1", ERR_SHORT);
        end
        for (int i = 1; i < N; i++) send_byte(8'h55, 1'b0);
        pulse_update();
        exp_bus = {N{8'h55}};
        checks++;
        if (L1_BUS_OUT !== exp_bus) begin
            errors++;
            $display("FAIL short_bus got=%h want=%h", L1_BUS_OUT, exp_bus);
        end
        idle_cycles(2);
        checks++;
        if (n_short - s0 !== 1 || n_changed - c0 !== 1) begin
            errors++;
            $display("FAIL short_counts got=%0d/%0d want=1/1",
                     n_short - s0, n_changed - c0);
        end
    endtask

    task automatic test_orphan_bytes;
        int l0;
        l0 = n_long;
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
        idle_cycles(1);
        checks++;
        if (n_long - l0 !== 3 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL orphan_idle got=%0d pend=%b want=3 pend=0",
                     n_long - l0, PENDING);
        end
        pulse_update();
        checks++;
        if (L1_BUS_OUT !== exp_bus) begin
            errors++;
            $display("FAIL orphan_noupdate got=%h want=%h", L1_BUS_OUT, exp_bus);
        end
        send_block(8'h33, 1'b0);
        l0 = n_long;
        for (int i = 0; i < 3; i++) send_byte(8'hEE, 1'b0);
        idle_cycles(1);
        checks++;
        if (n_long - l0 !== 3 || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL orphan_pending got=%0d pend=%b want=3 pend=1",
                     n_long - l0, PENDING);
        end
        pulse_update();
        exp_bus = {N{8'h33}};
        checks++;
        if (L1_BUS_OUT !== exp_bus) begin
            errors++;
            $display("FAIL orphan_shadow got=%h want=%h", L1_BUS_OUT, exp_bus);
        end
        idle_cycles(1);
        send_block(8'h40, 1'b1);
        pulse_update();
        for (int i = 0; i < N; i++) exp_bus[8*i +: 8] = 8'h40 + 8'(i);
        checks++;
        if (L1_BUS_OUT !== exp_bus) begin
            errors++;
            $display("FAIL orphan_counter got=%h want=%h", L1_BUS_OUT, exp_bus);
        end
    endtask

    task automatic test_timing_edges;
        logic [W-1:0] old_bus;
        int c0;
        old_bus = exp_bus;
        for (int i = 0; i < N - 1; i++) send_byte(8'h77, i == 0);
        UPDATE = 1'b1;
        send_byte(8'h77, 1'b0);
        UPDATE = 1'b0;
        checks++;
        if (L1_BUS_OUT !== old_bus || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL edge_coincident got=%h pend=%b want=%h pend=1",
                     L1_BUS_OUT, PENDING, old_bus);
        end
        idle_cycles(4);
        pulse_update();
        exp_bus = {N{8'h77}};
        checks++;
        if (L1_BUS_OUT !== exp_bus || L1_CHANGED !== 1'b1) begin
            errors++;
            $display("FAIL edge_late_update got=%h chg=%b want=%h chg=1",
                     L1_BUS_OUT, L1_CHANGED, exp_bus);
        end
        idle_cycles(1);
        c0 = n_changed;
        pulse_update();
        idle_cycles(1);
        checks++;
        if (L1_BUS_OUT !== exp_bus || n_changed - c0 !== 0) begin
            errors++;
            $display("FAIL edge_idle_update got=%h chg=%0d want=%h chg=0",
                     L1_BUS_OUT, n_changed - c0, exp_bus);
        end
    endtask

    task automatic test_reset_mid_load;
        for (int i = 0; i <= 20; i++) send_byte(8'h90, i == 0);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (L1_BUS_OUT !== '0 || L1_VALID !== 1'b0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL midreset got=%h val=%b pend=%b want=0 val=0 pend=0",
                     L1_BUS_OUT, L1_VALID, PENDING);
        end
        @(negedge CLK);
        RST = 1'b1;
        idle_cycles(1);
        send_block(8'h05, 1'b1);
        pulse_update();
        for (int i = 0; i < N; i++) exp_bus[8*i +: 8] = 8'h05 + 8'(i);
        checks++;
        if (L1_BUS_OUT !== exp_bus || L1_VALID !== 1'b1 || L1_CHANGED !== 1'b1) begin
            errors++;
            $display("FAIL postreset got=%h val=%b chg=%b want=%h val=1 chg=1",
                     L1_BUS_OUT, L1_VALID, L1_CHANGED, exp_bus);
        end
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_identical_reload();
        test_short_block();
        test_orphan_bytes();
        test_timing_edges();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule
